// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings and state/operation enums used by the
// decoder, the single-cycle ALU and the serial execute unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } alu_state_e;

  typedef enum logic [1:0] {
    SliceAdd,
    SliceAnd,
    SliceOr
  } slice_op_e;

  function automatic logic alu_code_legal(input logic [2:0] code);
    return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_AND) ||
           (code == ALU_OR)  || (code == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit add/and/or unit; the caller pre-inverts B for subtraction
// and supplies the incoming carry.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b_inverted,
  input  logic             carry_in,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] sum,
  output logic             carry_out,
  output logic             msb_overflow
);

  logic [SLICE:0] add_full;

  assign add_full = {1'b0, a} + {1'b0, b_inverted} + {{SLICE{1'b0}}, carry_in};

  // Signed overflow of the adder at this slice's top bit; meaningful on the last slice.
  assign msb_overflow = (a[SLICE-1] == b_inverted[SLICE-1]) &&
                        (add_full[SLICE-1] != a[SLICE-1]);

  always_comb begin
    sum       = add_full[SLICE-1:0];
    carry_out = add_full[SLICE];
    case (op)
      SliceAnd: begin
        sum       = a & b_inverted;
        carry_out = 1'b0;
      end
      SliceOr: begin
        sum       = a | b_inverted;
        carry_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_exec.sv
// Bit-serial ALU: executes add/sub/and/or/slt SLICE bits per cycle, LSB first,
// behind valid/ready handshakes on operand and result sides.
module alu_serial_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned NumSlices = (SLICE == 0) ? 1 : WIDTH / SLICE;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("alu_serial_exec: SLICE must be nonzero and divide WIDTH evenly");
  end

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, zero_q, zero_d, illegal_q, illegal_d;

  logic [SLICE-1:0] a_slice, b_slice, sum;
  logic [1:0]       slice_op;
  logic             invert_b, carry_out, msb_overflow, last_slice;
  logic [WIDTH-1:0] final_value;

  assign invert_b   = (op_q == ALU_SUB) || (op_q == ALU_SLT);
  assign a_slice    = a_q[cnt_q * SLICE +: SLICE];
  assign b_slice    = invert_b ? ~b_q[cnt_q * SLICE +: SLICE] : b_q[cnt_q * SLICE +: SLICE];
  assign slice_op   = (op_q == ALU_AND) ? SliceAnd : (op_q == ALU_OR) ? SliceOr : SliceAdd;
  assign last_slice = (cnt_q == CntW'(NumSlices - 1));

  alu_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a           (a_slice),
    .b_inverted  (b_slice),
    .carry_in    (carry_q),
    .op          (slice_op),
    .sum         (sum),
    .carry_out   (carry_out),
    .msb_overflow(msb_overflow)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    final_value = result_q;
    final_value[cnt_q * SLICE +: SLICE] = sum;
    // slt replaces the difference with the signed less-than bit: sign XOR overflow.
    if (op_q == ALU_SLT) begin
      final_value = {{(WIDTH - 1){1'b0}}, sum[SLICE-1] ^ msb_overflow};
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = src_a;
          b_d       = src_b;
          op_d      = alu_control;
          cnt_d     = '0;
          illegal_d = 1'b0;
          if (alu_code_legal(alu_control)) begin
            carry_d = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
            state_d = StRun;
          end else begin
            carry_d   = 1'b0;
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StRun: begin
        carry_d = carry_out;
        if (last_slice) begin
          cnt_d    = '0;
          result_d = final_value;
          zero_d   = (final_value == '0);
          state_d  = StDone;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          result_d[cnt_q * SLICE +: SLICE] = sum;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboard bench for alu_serial_exec: directed and random operations checked
// against an arithmetic reference model by an independent output monitor.
module tb_alu_serial_exec;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned Slices = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         illegal;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a, src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  exp_t cur;
  logic in_done = 1'b0;
  logic bp_mode = 1'b0;
  logic force_ready = 1'b1;

  alu_serial_exec #(
    .WIDTH(W),
    .SLICE(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : force_ready;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    e.illegal = 1'b0;
    e.lat     = Slices + 1;
    e.acc     = 0;
    case (op)
      3'b000:  e.res = a + b;
      3'b001:  e.res = a - b;
      3'b010:  e.res = a & b;
      3'b011:  e.res = a | b;
      3'b101:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.res     = '0;
        e.illegal = 1'b1;
        e.lat     = 1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 within 100 cycles");
      return;
    end
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    e           = model(op, a, b);
    e.acc       = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    src_a       = $urandom;
    src_b       = $urandom;
    alu_control = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
  endtask

  // Monitor: compares each new result presentation against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      in_done = 1'b0;
    end else begin
      if (out_valid && !in_done) begin
        in_done = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out_valid: got result %h expected no output", result);
        end else begin
          cur = sb.pop_front();
          check("latency", W'(cyc - cur.acc + 1), W'(cur.lat));
          check("result", result, cur.res);
          if (!cur.illegal) check("zero", W'(zero), W'(cur.zero));
          check("illegal", W'(illegal), W'(cur.illegal));
          check("in_ready_in_done", W'(in_ready), 32'd0);
        end
      end
      if (!out_valid || out_ready) in_done = 1'b0;
    end
  end

  initial begin
    logic [2:0]   legal_ops[5];
    logic [2:0]   bad_ops[3];
    logic [2:0]   op;
    logic [W-1:0] a, b;
    exp_t         e;
    int           n;
    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    bad_ops   = '{3'b100, 3'b110, 3'b111};

    reset = 1'b1;
    in_valid = 1'b0;
    alu_control = '0;
    src_a = '0;
    src_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), 32'd1);
    check("rst_out_valid", W'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", W'(zero), 32'd0);
    check("rst_illegal", W'(illegal), 32'd0);

    issue(ALU_ADD, 32'h0000_00FF, 32'h0000_0001);
    issue(ALU_SUB, 32'h1234_5678, 32'h1234_5678);
    issue(ALU_SUB, 32'h0, 32'h1);
    issue(ALU_SLT, 32'h8000_0000, 32'h0000_0001);
    issue(ALU_SLT, 32'h5, 32'hFFFF_FFFF);
    issue(ALU_SLT, 32'h3, 32'h3);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(ALU_OR, 32'h0F0F_0000, 32'h0000_F0F0);
    issue(3'b111, 32'hDEAD_BEEF, 32'h1);
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 9);
      op = (n < 8) ? legal_ops[n % 5] : bad_ops[n % 3];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        1: a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        2: b = a;
        default: ;
      endcase
      issue(op, a, b);
    end
    drain();
    bp_mode = 1'b0;

    // Backpressure: result must hold in DONE and new requests must be ignored.
    force_ready = 1'b0;
    @(posedge clk); #1;
    e = model(ALU_SUB, 32'h0000_1000, 32'h0000_0001);
    issue(ALU_SUB, 32'h0000_1000, 32'h0000_0001);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid    = 1'b1;
      alu_control = ALU_ADD;
      src_a       = $urandom;
      src_b       = $urandom;
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), 32'd1);
      check("bp_in_ready", W'(in_ready), 32'd0);
      check("bp_result", result, e.res);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    force_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", W'(out_valid), 32'd0);
    check("bp_release_in_ready", W'(in_ready), 32'd1);
    check("bp_release_result", result, e.res);

    // Reset during the second RUN cycle aborts without emitting a result.
    issue(ALU_SUB, 32'h0000_0100, 32'h0000_0003);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_in_ready", W'(in_ready), 32'd1);
    check("mid_rst_out_valid", W'(out_valid), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", W'(zero), 32'd0);
    check("mid_rst_illegal", W'(illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", W'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_exec.md
Name: alu_serial_exec

Overview:
- Execute-side consumer of the 3-bit ALUControl code produced by the ALU decoder.
- Performs add, sub, and, or and slt on two operands, SLICE bits per clock, LSB first.
- Uses valid/ready handshakes on both the operand side and the result side.
- Intended for the area-reduced multi-cycle core variant; also produces the zero flag used for branch resolution.

Parameters:
- WIDTH, 32: operand and result width in bits.
- SLICE, 8: bits processed per RUN cycle. Must divide WIDTH evenly; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and code are valid
- in_ready  out  1  block can accept an operation
- alu_control  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- illegal  out  1  code was not a supported encoding

Behaviour:
- Clock/reset (already decided): one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - result = 0, zero = 0, illegal = 0
  - internal operand registers, slice counter and carry = 0
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no result is emitted.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE: when in_valid is high, capture src_a, src_b and alu_control.
  - Supported code: load carry = 1 for sub/slt, else 0. Clear the slice counter. Go to RUN.
  - Unsupported code (100, 110, 111): result = 0, illegal = 1, go directly to DONE.
- RUN: each cycle, process bits [k*SLICE +: SLICE], where k is the counter.
  - add: A + B + carry.
  - sub/slt: A + ~B + carry.
  - and/or: bitwise on the slice; carry is unused.
  - The carry out of slice k feeds slice k+1.
  - Write the result slice into the result register; increment k.
  - After slice WIDTH/SLICE-1, go to DONE.
- Latency from accept to out_valid = WIDTH/SLICE + 1 cycles (5 with defaults).
- slt:
  - Signed compare: lt = sign(A-B) XOR signed overflow.
  - Overflow = (A[msb] != B[msb]) AND (diff[msb] != A[msb]).
  - In the cycle entering DONE, result = {WIDTH-1 zeros, lt}.
- Width rules:
  - add/sub wrap modulo 2^WIDTH.
  - The final carry out is discarded; no carry flag is exported.
- zero and illegal are registered together with the final result value and are stable throughout DONE.
- DONE:
  - result, zero and illegal hold while out_ready is low.
  - When out_ready is high, go to IDLE in the next cycle with out_valid = 0.
  - result holds its last value and illegal holds until the next accept.
- in_valid outside IDLE is ignored, since in_ready = 0. Inputs are sampled only on accept.
  - Inputs changing during RUN have no effect.
- Throughput: at most one operation per WIDTH/SLICE + 2 cycles. There is no overlap between DONE and a new accept.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control localparams: ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101.
  - The FSM state encoding.
  - Both are shared with the ALU decoder and the single-cycle ALU.
- One sub-module, alu_slice:
  - Purely combinational SLICE-bit add/and/or unit.
  - Inputs: a, b_inverted, carry_in, op.
  - Outputs: sum, carry_out, msb_overflow.
- The top level owns the FSM, the counter and the registers.

Test Plan:
1. Reset held 3 cycles, then released -> in_ready = 1, out_valid = 0, result = 0, zero = 0, illegal = 0.
2. add 0x0000_00FF + 0x0000_0001, out_ready = 1 -> out_valid exactly 5 cycles after accept. Result 0x0000_0100, zero = 0. Carry must cross the slice boundary.
3. sub 0x1234_5678 - 0x1234_5678 -> result 0, zero = 1.
   - Repeat as 0 - 1 -> result 0xFFFF_FFFF, zero = 0.
4. slt cases, each with out_ready = 1:
   - 0x8000_0000 vs 0x0000_0001 -> result 1 (overflow case).
   - 5 vs 0xFFFF_FFFF -> result 0.
   - 3 vs 3 -> result 0, zero = 1.
5. Logic ops and illegal code:
   - and 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xF000_F000.
   - or 0x0F0F_0000 | 0x0000_F0F0 -> 0x0F0F_F0F0.
   - alu_control = 3'b111 -> out_valid 1 cycle after accept, result 0, illegal = 1.
6. Backpressure and mid-operation reset:
   - Hold out_ready = 0 for 10 cycles in DONE -> result stable, in_ready = 0, new in_valid ignored. Raising out_ready returns the block to IDLE on the next cycle.
   - Assert reset during RUN cycle 2 -> outputs at reset values immediately. No spurious out_valid afterwards.
